fpga_mem_responder: RTL and testbench
=====================================

# fpga_mem_responder

Responder side of the on-chip memory port driven by `FPGA_Mem_OP`. It accepts chip-select/clock-enable/write requests with per-lane byte enables, stores words in an internal single-port array, and returns read data exactly one cycle after the request. After reset, a clear sequencer zeroes the whole array before service starts. The block stands in for the Platform Designer on-chip RAM in simulation and in standalone FPGA builds, and also exposes access statistics.

## Interface
- `ADDR_WIDTH`, default 11: word address width; DEPTH = 2**ADDR_WIDTH words.
- `WORD_WIDTH`, default 256: data word width.
- `BYTEENABLE_WIDTH`, default 32: number of write lanes. LANE = WORD_WIDTH / BYTEENABLE_WIDTH bits per lane; exact division is required.
- `CNT_WIDTH`, default 16: width of the statistics counters.

- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `mem_addr`  input  ADDR_WIDTH  word address.
- `mem_chipselect`  input  1  request valid.
- `mem_clken`  input  1  clock enable; when low, the block is frozen for that cycle.
- `mem_write`  input  1  1 = write, 0 = read (qualified by `mem_chipselect`).
- `mem_writedata`  input  WORD_WIDTH  write data.
- `mem_byteenable`  input  BYTEENABLE_WIDTH  lane i enables bits [i*LANE +: LANE].
- `mem_readdata`  output  WORD_WIDTH  registered read data.
- `init_busy`  output  1  high while the clear sequencer runs.
- `rd_count`  output  CNT_WIDTH  accepted reads, saturating.
- `wr_count`  output  CNT_WIDTH  accepted writes, saturating.
- `drop_count`  output  CNT_WIDTH  requests ignored during INIT, saturating.

## Operation
- State machine has two states: INIT and READY.
  - Reset enters INIT with the clear pointer at 0.
  - INIT: each cycle writes all-zero to mem[ptr], then ptr+1. The cycle that writes DEPTH-1 transitions to READY.
  - READY is permanent until the next reset.
- Accepted request: READY & `mem_chipselect` & `mem_clken`.
- Accepted write: for each lane i with `mem_byteenable[i]`=1, mem[addr] lane i ← `mem_writedata` lane i. Disabled lanes keep their old value. `mem_readdata` is unchanged. `wr_count`+1.
- Accepted read: `mem_readdata` ← mem[addr]. `rd_count`+1. `mem_byteenable` is ignored on reads.
- No accepted request: `mem_readdata` holds its last value.
- `mem_clken`=0: no array write, no `mem_readdata` update, no counter update, regardless of the other inputs.
- Request during INIT (`mem_chipselect` & `mem_clken`): ignored. The array is not modified, `mem_readdata` holds, and `drop_count`+1. The clear sequencer is not stalled by requests or by `mem_clken`.
- Counters saturate at all-ones and never wrap.
- The array itself has no reset. Its contents are defined only by the clear sequence and by subsequent writes.

## Timing
- Reset values (asserted asynchronously): `mem_readdata`=0, `init_busy`=1, all counters 0, state INIT, ptr 0.
- INIT lasts exactly DEPTH cycles after `reset_n` deasserts (2048 at default). `init_busy` falls on the edge that writes mem[DEPTH-1]. The first request accepted is the one sampled on the following edge.
- Read latency is 1. A read sampled at edge N presents data on `mem_readdata` after edge N; the initiator samples it at edge N+1.
- Write then read of the same address on consecutive edges returns the newly written data.
- Back-to-back reads, one per cycle, are supported with no bubbles.
- The port is single: one request per cycle, and `mem_write` selects its type.
- Reset asserted mid-INIT or mid-READY: the block immediately returns to reset values and the clear restarts from address 0. A read in flight is discarded (`mem_readdata`=0).

## Test plan
- Reset release: hold `mem_chipselect`=0 and count cycles. Required: `init_busy`=1 for exactly 2048 cycles, then 0. Reads of addresses 0, 1023 and 2047 all return 0.
- Full write/read: write 256'h0123…EF (all lanes enabled) to addr 5, then read addr 5 on the next cycle. Required: `mem_readdata` equals the written word one cycle after the read. `wr_count`=1, `rd_count`=1.
- Byte-enable merge: write all-ones to addr 9, then write all-zero with `mem_byteenable`=32'h0000_00F0. Read addr 9. Required: bits [63:32]=0 and all other bits 1.
- Clken and INIT drops: issue 3 requests during INIT, then a write to addr 7 with `mem_clken`=0 in READY. Required: `drop_count`=3, `wr_count`=0, and mem[7] still 0.
- Back-to-back reads and saturation: read addrs 1, 2, 3 on consecutive cycles after writing 11, 22, 33. Required: `mem_readdata` sequence 11, 22, 33 with no gaps. Then with `CNT_WIDTH`=4, 20 reads leave `rd_count`=4'hF.
- Mid-operation reset: pulse `reset_n` low between a read request and its data cycle. Required: `mem_readdata`=0, counters 0, `init_busy`=1, and mem[5] reads back as 0 after INIT completes.

Source files
------------

// File: rtl/fpga_mem_responder.sv
// On-chip memory responder: byte-lane writes, 1-cycle reads,
// post-reset array clear and saturating access statistics.
module fpga_mem_responder #(
  parameter int ADDR_WIDTH       = 11,
  parameter int WORD_WIDTH       = 256,
  parameter int BYTEENABLE_WIDTH = 32,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [ADDR_WIDTH-1:0]       mem_addr,
  input  logic                        mem_chipselect,
  input  logic                        mem_clken,
  input  logic                        mem_write,
  input  logic [WORD_WIDTH-1:0]       mem_writedata,
  input  logic [BYTEENABLE_WIDTH-1:0] mem_byteenable,
  output logic [WORD_WIDTH-1:0]       mem_readdata,
  output logic                        init_busy,
  output logic [CNT_WIDTH-1:0]        rd_count,
  output logic [CNT_WIDTH-1:0]        wr_count,
  output logic [CNT_WIDTH-1:0]        drop_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LANE  = WORD_WIDTH / BYTEENABLE_WIDTH;

  typedef enum logic {
    INIT,
    READY
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  req;
  logic                  acc_rd;
  logic                  acc_wr;
  logic                  drop;

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= INIT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:    if (&ptr) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    init_busy = 1'b0;
    req       = mem_chipselect & mem_clken;
    acc_rd    = 1'b0;
    acc_wr    = 1'b0;
    drop      = 1'b0;
    unique case (state)
      INIT: begin
        init_busy = 1'b1;
        drop      = req;
      end
      READY: begin
        acc_rd = req & ~mem_write;
        acc_wr = req & mem_write;
      end
      default: init_busy = 1'b1;
    endcase
  end

  // Clear pointer runs every INIT cycle, independent of clken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       ptr <= '0;
    else if (init_busy) ptr <= ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (init_busy) begin
      mem[ptr] <= '0;
    end else if (acc_wr) begin
      for (int i = 0; i < BYTEENABLE_WIDTH; i++) begin
        if (mem_byteenable[i])
          mem[mem_addr][i*LANE +: LANE] <=
            mem_writedata[i*LANE +: LANE];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    mem_readdata <= '0;
    else if (acc_rd) mem_readdata <= mem[mem_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_count   <= '0;
      wr_count   <= '0;
      drop_count <= '0;
    end else begin
      if (acc_rd) rd_count   <= sat_inc(rd_count);
      if (acc_wr) wr_count   <= sat_inc(wr_count);
      if (drop)   drop_count <= sat_inc(drop_count);
    end
  end

endmodule

// File: tb/tb_fpga_mem_responder.sv
// Randomized bench for fpga_mem_responder with a behavioural model
// and a narrow saturating-counter instance sharing the stimulus.
module tb_fpga_mem_responder;

  localparam int DEPTH  = 2048;
  localparam int DEPTH2 = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [10:0]  mem_addr = '0;
  logic         mem_chipselect = 1'b0;
  logic         mem_clken = 1'b0;
  logic         mem_write = 1'b0;
  logic [255:0] mem_writedata = '0;
  logic [31:0]  mem_byteenable = '0;
  logic [255:0] mem_readdata;
  logic         init_busy;
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;
  logic [15:0]  drop_count;

  logic [31:0]  s_readdata;
  logic         s_busy;
  logic [3:0]   s_rd;
  logic [3:0]   s_wr;
  logic [3:0]   s_drop;

  always #5 clk = ~clk;

  fpga_mem_responder u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_addr       (mem_addr),
    .mem_chipselect (mem_chipselect),
    .mem_clken      (mem_clken),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .mem_readdata   (mem_readdata),
    .init_busy      (init_busy),
    .rd_count       (rd_count),
    .wr_count       (wr_count),
    .drop_count     (drop_count)
  );

  fpga_mem_responder #(
    .ADDR_WIDTH       (4),
    .WORD_WIDTH       (32),
    .BYTEENABLE_WIDTH (4),
    .CNT_WIDTH        (4)
  ) u_sat (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_addr       (mem_addr[3:0]),
    .mem_chipselect (mem_chipselect),
    .mem_clken      (mem_clken),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata[31:0]),
    .mem_byteenable (mem_byteenable[3:0]),
    .mem_readdata   (s_readdata),
    .init_busy      (s_busy),
    .rd_count       (s_rd),
    .wr_count       (s_wr),
    .drop_count     (s_drop)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Behavioural model: array is all-zero once the clear has run.
  logic [255:0] m_mem [DEPTH];
  logic [255:0] m_rd;
  int m_init, m_rdc, m_wrc, m_drop;
  int m2_init, m2_rd, m2_wr, m2_drop;

  function automatic int sat(input int v, input int mx);
    return (v < mx) ? v + 1 : mx;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_init = DEPTH;
      m2_init = DEPTH2;
      m_rd = '0;
      m_rdc = 0; m_wrc = 0; m_drop = 0;
      m2_rd = 0; m2_wr = 0; m2_drop = 0;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else begin
      if (mem_chipselect && mem_clken) begin
        if (m_init > 0) m_drop = sat(m_drop, 65535);
        else if (mem_write) begin
          for (int i = 0; i < 32; i++)
            if (mem_byteenable[i])
              m_mem[mem_addr][i*8 +: 8] = mem_writedata[i*8 +: 8];
          m_wrc = sat(m_wrc, 65535);
        end else begin
          m_rd = m_mem[mem_addr];
          m_rdc = sat(m_rdc, 65535);
        end
        if (m2_init > 0) m2_drop = sat(m2_drop, 15);
        else if (mem_write) m2_wr = sat(m2_wr, 15);
        else m2_rd = sat(m2_rd, 15);
      end
      if (m_init > 0) m_init--;
      if (m2_init > 0) m2_init--;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("readdata", mem_readdata, m_rd);
      chk("init_busy", 256'(init_busy), 256'(m_init > 0));
      chk("rd_count", 256'(rd_count), 256'(m_rdc));
      chk("wr_count", 256'(wr_count), 256'(m_wrc));
      chk("drop_count", 256'(drop_count), 256'(m_drop));
      chk("s_busy", 256'(s_busy), 256'(m2_init > 0));
      chk("s_rd", 256'(s_rd), 256'(m2_rd));
      chk("s_wr", 256'(s_wr), 256'(m2_wr));
      chk("s_drop", 256'(s_drop), 256'(m2_drop));
    end
  end

  task automatic step(input logic cs, input logic ce, input logic wr,
                      input logic [10:0] a, input logic [255:0] d,
                      input logic [31:0] be);
    mem_chipselect = cs;
    mem_clken = ce;
    mem_write = wr;
    mem_addr = a;
    mem_writedata = d;
    mem_byteenable = be;
    @(negedge clk);
  endtask

  task automatic wr_full(input logic [10:0] a, input logic [255:0] d);
    step(1'b1, 1'b1, 1'b1, a, d, '1);
  endtask

  task automatic rd(input logic [10:0] a);
    step(1'b1, 1'b1, 1'b0, a, '0, '0);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic rnd_step();
    step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
         $urandom_range(0, 1) == 1, 11'($urandom_range(0, 31)),
         rnd256(), $urandom);
  endtask

  int cycles;
  logic [255:0] w;
  logic [255:0] e;

  initial begin
    w = {4{64'h0123_4567_89AB_CDEF}};
    repeat (3) @(negedge clk);
    chk("rst_readdata", mem_readdata, '0);
    chk("rst_busy", 256'(init_busy), 256'(1));
    chk("rst_counts", {rd_count, wr_count, drop_count}, '0);
    reset_n = 1'b1;

    cycles = 0;
    while (init_busy && cycles < 5000) begin
      cycles++;
      if (cycles >= 10 && cycles <= 12)
        step(1'b1, 1'b1, cycles[0], 11'd7, '1, '1);
      else
        step(1'b0, 1'b0, 1'b0, '0, '0, '0);
    end
    chk("init_cycles", 256'(cycles), 256'(2048));
    chk("init_drops", 256'(drop_count), 256'(3));

    step(1'b1, 1'b0, 1'b1, 11'd7, '1, '1);
    rd(11'd7);
    chk("clken_mem7", mem_readdata, '0);
    chk("clken_wr", 256'(wr_count), 256'(0));
    chk("clken_rd", 256'(rd_count), 256'(1));
    rd(11'd0);
    rd(11'd1023);
    rd(11'd2047);
    chk("clear_2047", mem_readdata, '0);

    wr_full(11'd5, w);
    rd(11'd5);
    chk("full_rw", mem_readdata, w);
    chk("full_wr", 256'(wr_count), 256'(1));

    wr_full(11'd9, '1);
    step(1'b1, 1'b1, 1'b1, 11'd9, '0, 32'h0000_00F0);
    rd(11'd9);
    e = '1;
    e[63:32] = '0;
    chk("be_merge", mem_readdata, e);

    wr_full(11'd1, 256'd11);
    wr_full(11'd2, 256'd22);
    wr_full(11'd3, 256'd33);
    rd(11'd1);
    chk("b2b_1", mem_readdata, 256'd11);
    rd(11'd2);
    chk("b2b_2", mem_readdata, 256'd22);
    rd(11'd3);
    chk("b2b_3", mem_readdata, 256'd33);
    step(1'b0, 1'b1, 1'b0, 11'd1, '0, '0);
    chk("hold", mem_readdata, 256'd33);

    repeat (20) rd(11'd0);
    chk("sat_rd", 256'(s_rd), 256'(4'hF));

    repeat (3000) rnd_step();

    wr_full(11'd5, w);
    mem_chipselect = 1'b1;
    mem_clken = 1'b1;
    mem_write = 1'b0;
    mem_addr = 11'd5;
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_readdata", mem_readdata, '0);
    chk("mid_busy", 256'(init_busy), 256'(1));
    chk("mid_counts", {rd_count, wr_count, drop_count}, '0);
    @(negedge clk);
    mem_chipselect = 1'b0;
    reset_n = 1'b1;

    cycles = 0;
    while (init_busy && cycles < 5000) begin
      cycles++;
      rnd_step();
    end
    chk("init_cycles2", 256'(cycles), 256'(2048));
    rd(11'd5);
    chk("mid_mem5", mem_readdata, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
